// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit accumulation, priced vend, cancel/refund
// and coin-by-coin change dispensing. All outputs are registered.
// Optional build macro STOCK_COUNT_EN adds per-product stock counters and a sold_out port.
module vending_machine_multi #(
    parameter int unsigned           NUM_PROD   = 4,
    parameter int unsigned           CREDIT_W   = 8,
    parameter logic [8*NUM_PROD-1:0] PRICES     = {8'd5, 8'd4, 8'd3, 8'd2},
    parameter int unsigned           MAX_CREDIT = 20,
    parameter int unsigned           STOCK_INIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic [NUM_PROD-1:0] button,
    input  logic                cancel,
    output logic [NUM_PROD-1:0] product,
    output logic [1:0]          coin_out,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject
`ifdef STOCK_COUNT_EN
    ,
    output logic [NUM_PROD-1:0] sold_out
`endif
);

    // One extra bit so credit + coin can never wrap before the limit check.
    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam int unsigned IDX_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;

    // Reject parameter sets the credit register or stock counters cannot hold.
    if (MAX_CREDIT >= (2 ** CREDIT_W) || STOCK_INIT >= (2 ** 16)) begin : g_bad_cfg
        $error("vending_machine_multi: MAX_CREDIT or STOCK_INIT out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_CHANGE
    } state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [NUM_PROD-1:0] product_q, product_d;
    logic [1:0]          coin_out_q, coin_out_d;
    logic                busy_q, busy_d;
    logic                coin_reject_q, coin_reject_d;

    logic                pick_hit;
    logic [IDX_W-1:0]    pick_idx;
    logic                in_stock;
    logic [SUM_W-1:0]    credit_x;
    logic [SUM_W-1:0]    remain;

    function automatic logic [SUM_W-1:0] coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return SUM_W'(1);
            2'b10:   return SUM_W'(2);
            2'b11:   return SUM_W'(5);
            default: return '0;
        endcase
    endfunction

    function automatic logic [SUM_W-1:0] price_of(input logic [IDX_W-1:0] idx);
        return SUM_W'(PRICES[8 * int'(idx) +: 8]);
    endfunction

    // Lowest-index pressed button wins.
    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        for (int i = NUM_PROD - 1; i >= 0; i--) begin
            if (button[i]) begin
                pick_hit = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sel_d         = sel_q;
        product_d     = '0;
        coin_out_d    = 2'b00;
        busy_d        = 1'b0;
        coin_reject_d = 1'b0;
        credit_x      = SUM_W'(credit_q);
        remain        = '0;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel) begin
                    coin_reject_d = (coin != 2'b00);
                    if (credit_q != '0) begin
                        state_d = ST_CHANGE;
                        busy_d  = 1'b1;
                    end
                end else if (pick_hit && in_stock && credit_x >= price_of(pick_idx)) begin
                    state_d       = ST_VEND;
                    sel_d         = pick_idx;
                    busy_d        = 1'b1;
                    coin_reject_d = (coin != 2'b00);
                end else if (coin != 2'b00) begin
                    // A button that cannot vend does not block a coin.
                    remain = credit_x + coin_units(coin);
                    if (remain <= SUM_W'(MAX_CREDIT)) begin
                        credit_d = CREDIT_W'(remain);
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                product_d[sel_q] = 1'b1;
                remain           = credit_x - price_of(sel_q);
                credit_d         = CREDIT_W'(remain);
                coin_reject_d    = (coin != 2'b00);
                if (remain != '0) begin
                    state_d = ST_CHANGE;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (credit_x >= SUM_W'(5)) begin
                    coin_out_d = 2'b11;
                    remain     = credit_x - SUM_W'(5);
                end else if (credit_x >= SUM_W'(2)) begin
                    coin_out_d = 2'b10;
                    remain     = credit_x - SUM_W'(2);
                end else begin
                    coin_out_d = 2'b01;
                    remain     = credit_x - SUM_W'(1);
                end
                credit_d      = CREDIT_W'(remain);
                coin_reject_d = (coin != 2'b00);
                if (remain != '0) begin
                    busy_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            sel_q         <= '0;
            product_q     <= '0;
            coin_out_q    <= 2'b00;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_q         <= sel_d;
            product_q     <= product_d;
            coin_out_q    <= coin_out_d;
            busy_q        <= busy_d;
            coin_reject_q <= coin_reject_d;
        end
    end

`ifdef STOCK_COUNT_EN
    localparam int unsigned STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    logic [STOCK_W-1:0]  stock_q [NUM_PROD];
    logic [STOCK_W-1:0]  stock_d [NUM_PROD];
    logic [NUM_PROD-1:0] sold_out_q, sold_out_d;

    // Consume one unit of the vended product; flag empty products.
    always_comb begin
        stock_d = stock_q;
        if (state_q == ST_VEND) begin
            stock_d[sel_q] = stock_q[sel_q] - STOCK_W'(1);
        end
        for (int i = 0; i < NUM_PROD; i++) begin
            sold_out_d[i] = (stock_d[i] == '0);
        end
        in_stock = (stock_q[pick_idx] != '0);
    end

    // Stock counters and sold-out flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
            sold_out_q <= {NUM_PROD{STOCK_INIT == 0}};
        end else begin
            stock_q    <= stock_d;
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out = sold_out_q;
`else
    assign in_stock = 1'b1;
`endif

    assign product     = product_q;
    assign coin_out    = coin_out_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
    assign coin_reject = coin_reject_q;

endmodule
